// File: rtl/debounce_multi.sv
// N-channel key debouncer: 2-FF sync, shared tick prescaler, level plus press/release strobes; optional auto-repeat via DEBOUNCE_REPEAT_EN.
// Latency: 2 clk sync + wait to next tick + (STABLE-1)*2^DIV clk + 1 clk registered output.
// Backpressure: none; strobes are one-cycle pulses that cannot be stalled.
module debounce_multi #(
    parameter int N            = 4,
    parameter int DIV          = 16,
    parameter int STABLE       = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key,
    output logic [N-1:0] level,
    output logic [N-1:0] pos,
    output logic [N-1:0] neg,
    output logic         tick
);

    localparam int CW = $clog2(STABLE + 1);

    // Degenerate configurations leave an empty marker block in the elaborated hierarchy.
    if (N < 1 || DIV < 1 || STABLE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    end

    logic [DIV-1:0] pre;
    logic [N-1:0]   s;
    logic [N-1:0]   sync1;
    logic [N-1:0]   samp;

    assign s = (ACTIVE_LOW != 0) ? ~key : key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            tick  <= 1'b0;
            sync1 <= '0;
            samp  <= '0;
        end else begin
            pre   <= pre + 1'b1;
            tick  <= &pre;
            sync1 <= s;
            samp  <= sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl_q;
        logic          pos_q;
        logic          neg_q;
        logic          differ;
        logic          commit;
        logic          rpt_fire;

        assign differ = samp[i] != lvl_q;
        assign commit = tick && differ && (cnt == CW'(STABLE - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else if (tick) begin
                if (!differ) begin
                    cnt <= '0;
                end else if (commit) begin
                    lvl_q <= samp[i];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int RW   = $clog2(RMAX + 1);

        logic [RW-1:0] rcnt;
        logic          rrun;

        // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks.
        assign rpt_fire = tick && lvl_q && !commit &&
                          ((int'(rcnt) + 1) == (rrun ? REPEAT_RATE : REPEAT_DELAY));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt <= '0;
                rrun <= 1'b0;
            end else if (commit) begin
                rcnt <= '0;
                rrun <= 1'b0;
            end else if (tick && lvl_q) begin
                if (rpt_fire) begin
                    rcnt <= '0;
                    rrun <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos_q <= 1'b0;
                neg_q <= 1'b0;
            end else begin
                pos_q <= (commit && samp[i]) || rpt_fire;
                neg_q <= commit && !samp[i];
            end
        end

        assign level[i] = lvl_q;
        assign pos[i]   = pos_q;
        assign neg[i]   = neg_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised bench for debounce_multi (N=2, DIV=2, STABLE=3, ACTIVE_LOW=0) against a sample-history model.
// Define DEBOUNCE_REPEAT_EN on both bench and RTL to exercise auto-repeat (REPEAT_DELAY=4, REPEAT_RATE=2).
module tb_debounce_multi;

    localparam int STABLE = 3;
    localparam int RD     = 4;
    localparam int RR     = 2;
    localparam int TPER   = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key   = 2'b11;
    logic [1:0] level;
    logic [1:0] pos;
    logic [1:0] neg;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    debounce_multi #(
        .N(2), .DIV(2), .STABLE(STABLE), .ACTIVE_LOW(0),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .level(level), .pos(pos), .neg(neg), .tick(tick)
    );

    always #5 clk = ~clk;

    // Model: every tick sample is logged; a channel commits when the last STABLE
    // samples since its previous commit all disagree with its level.
    logic [1:0] m_s1    = 2'b00;
    logic [1:0] m_samp  = 2'b00;
    logic [1:0] m_level = 2'b00;
    logic [1:0] m_pos   = 2'b00;
    logic [1:0] m_neg   = 2'b00;
    logic       m_tick  = 1'b0;
    int         m_edges = 0;
    bit         hist [2][8192];
    int         hcnt [2];
    int         hlast[2];
    int         held [2];
    bit         ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 2'b00; m_samp = 2'b00; m_level = 2'b00;
            m_pos = 2'b00; m_neg = 2'b00; m_tick = 1'b0; m_edges = 0;
            for (int c = 0; c < 2; c++) begin
                hcnt[c] = 0; hlast[c] = 0; held[c] = 0;
            end
        end else begin
            m_pos = 2'b00;
            m_neg = 2'b00;
            if (m_tick) begin
                for (int c = 0; c < 2; c++) begin
                    hist[c][hcnt[c]] = m_samp[c];
                    hcnt[c]++;
                    ok = (hcnt[c] - hlast[c]) >= STABLE;
                    for (int j = 1; j <= STABLE; j++)
                        if (ok && hist[c][hcnt[c]-j] == m_level[c]) ok = 1'b0;
                    if (ok) begin
                        m_level[c] = m_samp[c];
                        if (m_samp[c]) m_pos[c] = 1'b1;
                        else           m_neg[c] = 1'b1;
                        hlast[c] = hcnt[c];
                        held[c]  = 0;
                    end else if (m_level[c]) begin
                        held[c]++;
`ifdef DEBOUNCE_REPEAT_EN
                        if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RR == 0))
                            m_pos[c] = 1'b1;
`endif
                    end
                end
            end
            m_samp = m_s1;
            m_s1   = key;
            m_edges++;
            m_tick = (m_edges % TPER) == 0;
        end
    end

    task automatic test_reset();
        int nt = 0;
        int rise = -1;
        rst_n = 1'b0;
        key   = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold got=%b want=0000000", {level, pos, neg, tick});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                failures++;
                $display("FAIL reset_model t=%0t got=%b want=%b", $time,
                         {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
            end
            if (tick) nt++;
            if (level[0] && rise < 0) rise = nt;
        end
        checks++;
        if (rise !== 3) begin
            failures++;
            $display("FAIL reset_first_rise ticks_got=%0d want=3", rise);
        end
    endtask

    task automatic test_clean_press();
        int npos0 = 0, npos1 = 0, nneg = 0;
        key = 2'b00;
        for (int i = 0; i < 40; i++) @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        key = 2'b01;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                failures++;
                $display("FAIL press_model t=%0t got=%b want=%b", $time,
                         {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
            end
            if (pos[0]) begin
                npos0++;
                checks++;
                if (level[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL press_pos_align level=%b want=1", level[0]);
                end
            end
            if (pos[1]) npos1++;
            if (|neg) nneg++;
        end
        checks++;
        if (npos0 !== 1 || npos1 !== 0 || nneg !== 0 || level !== 2'b01) begin
            failures++;
            $display("FAIL press_summary pos0=%0d pos1=%0d neg=%0d level=%b want 1 0 0 01",
                     npos0, npos1, nneg, level);
        end
    endtask

    task automatic test_bounce();
        bit pat[6] = '{1, 1, 0, 1, 1, 1};
        int nt = 0, rise = -1, npos = 0, n;
        key = 2'b00;
        for (int i = 0; i < 40; i++) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                checks++;
                if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                    failures++;
                    $display("FAIL bounce_model t=%0t got=%b want=%b", $time,
                             {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
                end
                if (pos[0]) npos++;
                if (level[0] && rise < 0) rise = nt;
            end while (!tick && n < 8);
            if (!tick) begin
                failures++;
                $display("FAIL bounce_tick_timeout got=0 want=1");
            end
            if (i > 0) nt++;
            key[0] = pat[i];
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick) nt++;
            if (pos[0]) npos++;
            if (level[0] && rise < 0) rise = nt;
        end
        checks++;
        if (rise !== 6 || npos !== 1) begin
            failures++;
            $display("FAIL bounce_rise tick_got=%0d want=6 pulses_got=%0d want=1", rise, npos);
        end
    endtask

    task automatic test_release_simult();
        int c0 = -1, c1 = -1, n0 = 0, n1 = 0, late_pos = 0;
        key = 2'b11;
        for (int i = 0; i < 40; i++) @(negedge clk);
        key = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                failures++;
                $display("FAIL release_model t=%0t got=%b want=%b", $time,
                         {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
            end
            if (neg[0]) begin n0++; c0 = i; end
            if (neg[1]) begin n1++; c1 = i; end
            if (|pos && c0 >= 0) late_pos++;
        end
        checks++;
        if (n0 !== 1 || n1 !== 1 || c0 !== c1 || level !== 2'b00 || late_pos !== 0) begin
            failures++;
            $display("FAIL release_simult neg0=%0d@%0d neg1=%0d@%0d level=%b late_pos=%0d want 1 1 same 00 0",
                     n0, c0, n1, c1, level, late_pos);
        end
    endtask

    task automatic test_async_reset();
        int n, r0 = -1, r1 = -1;
        key = 2'b10;
        for (int i = 0; i < 40; i++) @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!tick && n < 8);
            if (t == 0) key = 2'b11;
        end
        @(negedge clk);
        checks++;
        if (level !== 2'b10) begin
            failures++;
            $display("FAIL arst_pre_level got=%b want=10", level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, pos, neg, tick} !== 7'b0) begin
            failures++;
            $display("FAIL arst_immediate got=%b want=0000000", {level, pos, neg, tick});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                failures++;
                $display("FAIL arst_model t=%0t got=%b want=%b", $time,
                         {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
            end
            if (pos[0] && r0 < 0) r0 = i;
            if (pos[1] && r1 < 0) r1 = i;
        end
        checks++;
        if (r0 !== 13 || r1 !== 13) begin
            failures++;
            $display("FAIL arst_restart pos0_cycle=%0d pos1_cycle=%0d want=13", r0, r1);
        end
    endtask

    task automatic test_random();
        int both = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                failures++;
                $display("FAIL random_model t=%0t got=%b want=%b", $time,
                         {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
            end
            if (|(pos & neg)) both++;
            if ($urandom_range(0, 11) == 0) key[$urandom_range(0, 1)] ^= 1'b1;
        end
        checks++;
        if (both !== 0) begin
            failures++;
            $display("FAIL random_pos_neg_overlap got=%0d want=0", both);
        end
    endtask

`ifdef DEBOUNCE_REPEAT_EN
    task automatic test_repeat();
        int want[7] = '{0, 4, 6, 8, 10, 12, 14};
        int got[$];
        int nt = 0, c = -1, nneg = 0, pos_after_neg = 0;
        bit released = 1'b0;
        key = 2'b00;
        for (int i = 0; i < 40; i++) @(negedge clk);
        key = 2'b01;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if ({level, pos, neg, tick} !== {m_level, m_pos, m_neg, m_tick}) begin
                failures++;
                $display("FAIL repeat_model t=%0t got=%b want=%b", $time,
                         {level, pos, neg, tick}, {m_level, m_pos, m_neg, m_tick});
            end
            if (tick) nt++;
            if (pos[0]) begin
                if (c < 0) c = nt;
                if (nneg > 0) pos_after_neg++;
                got.push_back(nt - c);
            end
            if (neg[0]) nneg++;
            if (!released && c >= 0 && nt - c == 12 && pos[0]) begin
                key = 2'b00;
                released = 1'b1;
            end
        end
        checks++;
        if (got.size() !== 7 || nneg !== 1 || pos_after_neg !== 0) begin
            failures++;
            $display("FAIL repeat_count pulses=%0d want=7 neg=%0d want=1 late=%0d want=0",
                     got.size(), nneg, pos_after_neg);
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (got[k] !== want[k]) begin
                    failures++;
                    $display("FAIL repeat_offset idx=%0d got=%0d want=%0d", k, got[k], want[k]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_simult();
        test_async_reset();
        test_random();
`ifdef DEBOUNCE_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
